// File: rtl/sweep_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
// Shared definitions for the truth-table sweeper: the sequencer state type,
// default sizing constants and the settle-timer counter width.
// -----------------------------------------------------------------------------
package sweep_pkg;

    // Sequencer states; SETTLE holds a vector, SAMPLE captures the DUT result.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam int DEFAULT_N_IN          = 4;
    localparam int DEFAULT_SETTLE_CYCLES = 1;

    // Settle counter width, large enough for the maximum settle time of 255.
    localparam int TIMER_W = 8;

endpackage

// File: rtl/sweep_settle_timer.sv
// -----------------------------------------------------------------------------
// sweep_settle_timer
// Counts the cycles a vector has been held in SETTLE and flags the cycle in
// which the count reaches SETTLE_CYCLES-1.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   clear  in   forces the count back to zero (has priority over enable)
//   enable in   advances the count by one
//   tc     out  terminal count: count == SETTLE_CYCLES-1
// -----------------------------------------------------------------------------
module sweep_settle_timer
    import sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [TIMER_W-1:0] TC_VALUE = TIMER_W'(SETTLE_CYCLES - 1);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + TIMER_W'(1);
        end
    end

    assign tc = (count_q == TC_VALUE);

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Drives an N_IN-input combinational block through every input vector in
// ascending order, holds each vector SETTLE_CYCLES cycles, samples the
// single-bit result in the following cycle and builds the full truth table.
//
// Optional feature macro: SWEEP_COMPARE_EN -- adds the golden-table compare
// (expected / mismatch / mismatch_cnt ports).
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   starts a sweep when seen in IDLE (ignored with abort)
//   abort        in   returns to IDLE next cycle from any state, no done
//   dut_in       out  current vector, MSB = first DUT input
//   dut_out      in   DUT result for dut_in
//   table_out    out  bit i = result sampled while dut_in == i
//   busy         out  high in SETTLE and SAMPLE
//   done         out  one-cycle pulse when a sweep completes
//   expected     in   golden truth table          (SWEEP_COMPARE_EN)
//   mismatch     out  any table bit differs       (SWEEP_COMPARE_EN)
//   mismatch_cnt out  number of differing bits    (SWEEP_COMPARE_EN)
// -----------------------------------------------------------------------------
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN          = DEFAULT_N_IN,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 busy,
    output logic                 done
`ifdef SWEEP_COMPARE_EN
    ,
    input  logic [2**N_IN-1:0]   expected,
    output logic                 mismatch,
    output logic [N_IN:0]        mismatch_cnt
`endif
);

    localparam int            TABLE_W    = 2**N_IN;
    localparam logic [N_IN:0] LAST_INDEX = (N_IN+1)'(TABLE_W - 1);

    sweep_state_t       state_q;
    sweep_state_t       state_d;
    logic [N_IN:0]      index_q;
    logic [TABLE_W-1:0] table_q;
    logic               settle_tc;
    logic               accept;
    logic               sample_now;
    logic               last_vector;

    // The count is held at zero outside SETTLE, so every SETTLE entry starts
    // a fresh settle period without an explicit load.
    sweep_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != SETTLE),
        .enable (state_q == SETTLE),
        .tc     (settle_tc)
    );

    assign accept      = (state_q == IDLE) && start && !abort;
    assign sample_now  = (state_q == SAMPLE) && !abort;
    assign last_vector = (index_q == LAST_INDEX);

    // Next-state and Moore outputs; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        dut_in  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                busy   = 1'b1;
                dut_in = index_q[N_IN-1:0];
                if (settle_tc) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                busy    = 1'b1;
                dut_in  = index_q[N_IN-1:0];
                state_d = last_vector ? DONE : SETTLE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // State, vector index and truth-table capture. The index stops at the
    // last vector instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
            table_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                index_q <= '0;
                table_q <= '0;
            end else if (sample_now) begin
                table_q[index_q[N_IN-1:0]] <= dut_out;
                if (!last_vector) begin
                    index_q <= index_q + (N_IN+1)'(1);
                end
            end
        end
    end

    assign table_out = table_q;

`ifdef SWEEP_COMPARE_EN
    logic [TABLE_W-1:0] final_table;
    logic [TABLE_W-1:0] diff;
    logic [N_IN:0]      diff_cnt;

    // The compare is evaluated on the final table including the bit being
    // sampled, so the result is registered on entry to DONE and is visible
    // in the same cycle as done.
    always_comb begin
        final_table                     = table_q;
        final_table[index_q[N_IN-1:0]] = dut_out;
        diff                            = final_table ^ expected;
        diff_cnt                        = '0;
        for (int i = 0; i < TABLE_W; i++) begin
            diff_cnt = diff_cnt + (N_IN+1)'(diff[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else if (accept) begin
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else if (sample_now && last_vector) begin
            mismatch     <= |diff;
            mismatch_cnt <= diff_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Two sweepers (SETTLE_CYCLES = 1 and 3) share start/abort/rst and drive the
// same truth-table-defined function. A cycle-count reference model predicts
// every output; directed scenarios pin the model with literal expectations,
// then a randomized phase exercises start/abort/rst interleavings.
// Define SWEEP_COMPARE_EN to also check the golden-table compare outputs.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    localparam int N_IN = 4;
    localparam int TW   = 16;
    localparam int S_A  = 1;
    localparam int S_B  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [TW-1:0] func_tt;
    logic [TW-1:0] exp_tt;

    logic [N_IN-1:0] dut_in_a, dut_in_b;
    logic            dut_out_a, dut_out_b;
    logic [TW-1:0]   table_a, table_b;
    logic            busy_a, busy_b, done_a, done_b;
`ifdef SWEEP_COMPARE_EN
    logic            mis_a, mis_b;
    logic [N_IN:0]   cnt_a, cnt_b;
`endif

    int compared = 0;
    int mismatched = 0;
    bit checking_on = 1'b0;

    always #5 clk = ~clk;

    // The function under test is defined by its own truth table.
    assign dut_out_a = func_tt[dut_in_a];
    assign dut_out_b = func_tt[dut_in_b];

    truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYCLES(S_A)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .dut_in       (dut_in_a),
        .dut_out      (dut_out_a),
        .table_out    (table_a),
        .busy         (busy_a),
        .done         (done_a)
`ifdef SWEEP_COMPARE_EN
        ,
        .expected     (exp_tt),
        .mismatch     (mis_a),
        .mismatch_cnt (cnt_a)
`endif
    );

    truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYCLES(S_B)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .dut_in       (dut_in_b),
        .dut_out      (dut_out_b),
        .table_out    (table_b),
        .busy         (busy_b),
        .done         (done_b)
`ifdef SWEEP_COMPARE_EN
        ,
        .expected     (exp_tt),
        .mismatch     (mis_b),
        .mismatch_cnt (cnt_b)
`endif
    );

    // Reference model: each sweep is described by the number of edges since
    // start was accepted. Vector k is presented during edges k*(S+1) ..
    // (k+1)*(S+1)-1 and sampled at edge (k+1)*(S+1); the cycle after the
    // final sample is the done cycle.
    int            s_of[2] = '{S_A, S_B};
    bit            m_active[2] = '{1'b0, 1'b0};
    int            m_e[2] = '{0, 0};
    logic [TW-1:0] m_table[2] = '{16'h0, 16'h0};
    logic          m_mis[2] = '{1'b0, 1'b0};
    int            m_cnt[2] = '{0, 0};
    int            edge_count = 0;
    int            accept_edge[2] = '{0, 0};
    int            done_cycle[2] = '{-1, -1};

    always @(posedge clk) begin
        int            k;
        int            total;
        logic [TW-1:0] diff;
        edge_count++;
        for (int i = 0; i < 2; i++) begin
            total = TW * (s_of[i] + 1);
            if (rst) begin
                m_active[i] = 1'b0;
                m_table[i]  = '0;
                m_mis[i]    = 1'b0;
                m_cnt[i]    = 0;
            end else if (abort) begin
                m_active[i] = 1'b0;
            end else if (!m_active[i]) begin
                if (start) begin
                    m_active[i]    = 1'b1;
                    m_e[i]         = 0;
                    m_table[i]     = '0;
                    m_mis[i]       = 1'b0;
                    m_cnt[i]       = 0;
                    accept_edge[i] = edge_count;
                end
            end else begin
                m_e[i]++;
                if (m_e[i] > total) begin
                    m_active[i] = 1'b0;
                end else if (m_e[i] % (s_of[i] + 1) == 0) begin
                    k = m_e[i] / (s_of[i] + 1) - 1;
                    m_table[i][k] = func_tt[k];
                    if (k == TW - 1) begin
                        diff     = m_table[i] ^ exp_tt;
                        m_mis[i] = |diff;
                        m_cnt[i] = $countones(diff);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t",
                     name, actual, required, $time);
        end
    endtask

    task automatic checkInstance(input int i, input logic [N_IN-1:0] din,
                                 input logic b, input logic d,
                                 input logic [TW-1:0] t,
                                 input logic mis, input logic [N_IN:0] cnt);
        int   total;
        logic e_busy;
        logic e_done;
        int   e_in;
        total  = TW * (s_of[i] + 1);
        e_busy = m_active[i] && (m_e[i] < total);
        e_done = m_active[i] && (m_e[i] == total);
        e_in   = e_busy ? m_e[i] / (s_of[i] + 1) : 0;
        checkOutput($sformatf("busy[%0d]", i), 32'(b), 32'(e_busy));
        checkOutput($sformatf("done[%0d]", i), 32'(d), 32'(e_done));
        checkOutput($sformatf("dut_in[%0d]", i), 32'(din), 32'(e_in));
        checkOutput($sformatf("table_out[%0d]", i), 32'(t), 32'(m_table[i]));
`ifdef SWEEP_COMPARE_EN
        checkOutput($sformatf("mismatch[%0d]", i), 32'(mis), 32'(m_mis[i]));
        checkOutput($sformatf("mismatch_cnt[%0d]", i), 32'(cnt), 32'(m_cnt[i]));
`endif
        if (d === 1'b1 && done_cycle[i] < 0) begin
            done_cycle[i] = edge_count - accept_edge[i] + 1;
        end
    endtask

    // Every cycle, away from the active edge, compare both DUTs to the model.
    always @(negedge clk) begin
        if (checking_on) begin
`ifdef SWEEP_COMPARE_EN
            checkInstance(0, dut_in_a, busy_a, done_a, table_a, mis_a, cnt_a);
            checkInstance(1, dut_in_b, busy_b, done_b, table_b, mis_b, cnt_b);
`else
            checkInstance(0, dut_in_a, busy_a, done_a, table_a, 1'b0, '0);
            checkInstance(1, dut_in_b, busy_b, done_b, table_b, 1'b0, '0);
`endif
        end
    end

    task automatic applyStimulus(input logic s, input logic a, input logic r);
        @(negedge clk);
        start = s;
        abort = a;
        rst   = r;
    endtask

    task automatic idleCycles(input int n);
        for (int c = 0; c < n; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Runs a full sweep long enough for the slower instance to finish.
    task automatic fullSweep();
        done_cycle[0] = -1;
        done_cycle[1] = -1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(75);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        func_tt = 16'h8000;
        exp_tt  = 16'h0000;
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checking_on = 1'b1;
        checkOutput("reset busy", 32'(busy_a), 32'd0);
        checkOutput("reset done", 32'(done_a), 32'd0);
        checkOutput("reset dut_in", 32'(dut_in_a), 32'd0);
        checkOutput("reset table", 32'(table_a), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] 4-input AND sweep");
        fullSweep();
        checkOutput("and table_a", 32'(table_a), 32'h8000);
        checkOutput("and table_b", 32'(table_b), 32'h8000);
        checkOutput("and done cycle a", 32'(done_cycle[0]), 32'd33);
        checkOutput("and done cycle b", 32'(done_cycle[1]), 32'd65);

        $display("[TB] 4-input XOR sweep");
        func_tt = 16'h6996;
        exp_tt  = 16'h6997;
        fullSweep();
        checkOutput("xor table_a", 32'(table_a), 32'h6996);
        checkOutput("xor table_b", 32'(table_b), 32'h6996);
        checkOutput("xor done cycle b", 32'(done_cycle[1]), 32'd65);
`ifdef SWEEP_COMPARE_EN
        checkOutput("xor mismatch", 32'(mis_a), 32'd1);
        checkOutput("xor mismatch_cnt", 32'(cnt_a), 32'd1);
        exp_tt = 16'h6996;
        fullSweep();
        checkOutput("xor match mismatch", 32'(mis_b), 32'd0);
        checkOutput("xor match mismatch_cnt", 32'(cnt_b), 32'd0);
`endif

        $display("[TB] abort after edge 10");
        func_tt = 16'hFFFF;
        done_cycle[0] = -1;
        done_cycle[1] = -1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(10);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort table_a", 32'(table_a), 32'h001F);
        checkOutput("abort table_b", 32'(table_b), 32'h0003);
        checkOutput("abort busy", 32'(busy_a), 32'd0);
        checkOutput("abort dut_in", 32'(dut_in_a), 32'd0);
        idleCycles(70);
        checkOutput("abort no done", 32'(done_cycle[0]), 32'hFFFF_FFFF);

        $display("[TB] start re-pulse mid-sweep, start+abort in idle");
        func_tt = 16'h1234;
        done_cycle[0] = -1;
        done_cycle[1] = -1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(10);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(70);
        checkOutput("repulse done cycle", 32'(done_cycle[0]), 32'd33);
        checkOutput("repulse table", 32'(table_a), 32'h1234);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("start+abort busy", 32'(busy_a), 32'd0);
        checkOutput("start+abort table", 32'(table_a), 32'h1234);

        $display("[TB] reset mid-sweep");
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(19);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst table", 32'(table_a), 32'd0);
        checkOutput("rst busy", 32'(busy_b), 32'd0);
        checkOutput("rst dut_in", 32'(dut_in_b), 32'd0);
        func_tt = 16'hA5C3;
        fullSweep();
        checkOutput("post-rst table", 32'(table_b), 32'hA5C3);
        checkOutput("post-rst done cycle", 32'(done_cycle[0]), 32'd33);

        $display("[TB] randomized start/abort/rst");
        for (int c = 0; c < 3000; c++) begin
            if (c % 60 == 0) begin
                func_tt = 16'($urandom);
                exp_tt  = $urandom_range(0, 1) ? func_tt ^ 16'(1 << $urandom_range(0, 15))
                                               : 16'($urandom);
            end
            applyStimulus(($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 149) == 0),
                          ($urandom_range(0, 599) == 0));
        end
        idleCycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that exhaustively drives an N-input combinational unit under test through all 2^N input vectors in ascending binary order, waits a programmable settle time per vector, samples the single-bit result and assembles the complete truth table. It sits between a lab-board control interface (start/abort buttons, LEDs) and a combinational function block such as the 4-input `{a,b,c,d} -> f` circuits, replacing hand-written stimulus sequences with one synthesizable, self-checking sweep.

## Interface
- `N_IN`, 4, number of DUT inputs; vector index width
- `SETTLE_CYCLES`, 1, clock cycles each vector is held before sampling; legal range 1..255
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  begins a sweep when sampled high in IDLE
- `abort`  input  1  terminates a sweep; no `done` pulse
- `dut_in`  output  N_IN  vector to DUT; MSB = first input (`a`), LSB = last (`d`)
- `dut_out`  input  1  DUT result `f`
- `table_out`  output  2**N_IN  bit i = `f` sampled while `dut_in` = i
- `busy`  output  1  high in SETTLE and SAMPLE
- `done`  output  1  one-cycle pulse on sweep completion
- `expected`  input  2**N_IN  golden truth table (only with `SWEEP_COMPARE_EN`)
- `mismatch`  output  1  any bit differs (only with `SWEEP_COMPARE_EN`)
- `mismatch_cnt`  output  N_IN+1  number of differing bits (only with `SWEEP_COMPARE_EN`)

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: `dut_in`=0, `busy`=0. `start`=1 and `abort`=0 -> clear `table_out`, index=0, settle count=0 -> SETTLE.
- SETTLE: `dut_in`=index; count increments each cycle; when count reaches SETTLE_CYCLES-1 -> SAMPLE.
- SAMPLE: `table_out[index]` <= `dut_out`; if index = 2^N_IN-1 -> DONE, else index+1, count=0 -> SETTLE.
- DONE: `done`=1 for exactly this cycle -> IDLE.
- `abort`=1 in any state -> IDLE next cycle; `table_out` keeps partial contents; `done` not asserted; abort has priority over start in the same cycle.
- `start` while busy or in DONE ignored.
- Index is N_IN+1 wide internally; no wrap past 2^N_IN-1.
- `table_out` holds its value in IDLE until the next accepted `start`.

## Timing
- Reset: state=IDLE, `dut_in`=0, `table_out`=0, `busy`=0, `done`=0, `mismatch`=0, `mismatch_cnt`=0.
- `start` accepted at edge 0; vector k sampled at edge (k+1)(SETTLE_CYCLES+1); `done` high the cycle after the last sample: cycle 2^N_IN(SETTLE_CYCLES+1)+1. Defaults: cycle 33.
- `dut_in` changes only on SETTLE entry; stable for SETTLE_CYCLES+1 cycles including the sample cycle.
- `rst` mid-sweep: same as reset, takes effect at the next edge, overrides `abort`/`start`.

## Configuration
- `SWEEP_COMPARE_EN` defined: in DONE, `mismatch` <= |(`table_out` ^ `expected`), `mismatch_cnt` <= popcount of the same; both valid with `done`, held until next accepted `start` (cleared there). Abort leaves them at 0.
- Undefined: `expected`, `mismatch`, `mismatch_cnt` ports and logic absent.

## Structure
- Shared package `sweep_pkg`: state enum (IDLE, SETTLE, SAMPLE, DONE), default N_IN and SETTLE_CYCLES constants.
- One sub-module: `sweep_settle_timer` (load/clear, count, terminal-count flag sized for 255).
- Popcount kept inline under the macro.

## Test plan
- DUT = 4-input AND, defaults, pulse `start` -> `done` at cycle 33, `table_out`=16'h8000, `dut_in` walks 0..15 each held 2 cycles.
- DUT = 4-input XOR, SETTLE_CYCLES=3 -> `done` at cycle 65, `table_out`=16'h6996.
- `abort` at cycle 10 of a default sweep -> IDLE at 11, `done` never pulses, `table_out` bits 0..4 written, rest 0, `dut_in`=0.
- `start` re-pulsed mid-sweep and `start`+`abort` together in IDLE -> both ignored; sweep timing unchanged / state stays IDLE.
- `rst` held one cycle at cycle 20 -> all outputs 0 next cycle; fresh `start` completes normally.
- With `SWEEP_COMPARE_EN`, XOR DUT, `expected`=16'h6997 -> `mismatch`=1, `mismatch_cnt`=1 with `done`; `expected`=16'h6996 -> 0, 0.
